// File: rtl/axis_trans_pipe.sv
// Multi-lane saturating s +/- f adder with a two-stage valid/ready pipeline.
// Emits per-lane sign/magnitude and counts output beats that saturated.
`timescale 1ns/1ps
module axis_trans_pipe #(
  parameter int M     = 4,
  parameter int N     = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*(M+N)-1:0]   f_in,
  input  logic [LANES*(M+N)-1:0]   s_in,
  input  logic [LANES-1:0]         mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         sign,
  output logic [LANES*(M+N)-1:0]   mag,
  output logic [LANES-1:0]         ovf,
  output logic [CNT_W-1:0]         sat_cnt,
  input  logic                     cnt_clr
);

  localparam int W = M + N;
  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [LANES*W-1:0] sat_val;
  logic [LANES-1:0]   sat_ovf;
  logic [LANES*W-1:0] s1_val;
  logic [LANES-1:0]   s1_ovf;
  logic               v1;
  logic               v2;
  logic [LANES*W-1:0] mag_next;
  logic [LANES-1:0]   sign_next;
  logic               load2;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [W:0] a;
    logic signed [W:0] b;
    logic signed [W:0] r;
    logic [W-1:0]      v;

    // One guard bit is enough: overflow shows up as the top two bits disagreeing.
    assign a = {s_in[k*W+W-1], s_in[k*W +: W]};
    assign b = {f_in[k*W+W-1], f_in[k*W +: W]};
    assign r = mode[k] ? (a - b) : (a + b);
    assign sat_ovf[k] = r[W] ^ r[W-1];
    assign sat_val[k*W +: W] = sat_ovf[k] ? (r[W] ? MIN_VAL : MAX_VAL) : r[W-1:0];

    // The most negative value negates to itself, which reads correctly as unsigned.
    assign v = s1_val[k*W +: W];
    assign sign_next[k] = v[W-1];
    assign mag_next[k*W +: W] = v[W-1] ? (~v + 1'b1) : v;
  end

  assign in_ready  = !v1 || !v2 || out_ready;
  assign load2     = !v2 || out_ready;
  assign out_valid = v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      s1_val <= '0;
      s1_ovf <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_val <= sat_val;
        s1_ovf <= sat_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      sign <= '0;
      mag  <= '0;
      ovf  <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        sign <= sign_next;
        mag  <= mag_next;
        ovf  <= s1_ovf;
      end
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (v2 && out_ready && (|ovf) && (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule
